// File: rtl/jk_pkg.sv
// Shared constants for the JK excitation driver: FSM state encoding,
// {J,K} excitation codes and the legal upper bound of the check latency.
package jk_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  // Excitation codes are packed as {J,K}.
  localparam logic [1:0] EXC_HOLD = 2'b00;
  localparam logic [1:0] EXC_SET  = 2'b10;
  localparam logic [1:0] EXC_RST  = 2'b01;
  localparam logic [1:0] EXC_TOG  = 2'b11;

  localparam int CHECK_LAT_MAX = 15;
  localparam int CNT_W         = 4;

endpackage

// File: rtl/jk_excite_lut.sv
// Combinational JK excitation lookup: {J,K} that moves Q from q_cur to tgt_bit.
// Build option JK_TOGGLE_PREF_EN fills don't-cares with 1 (toggle) on changes.
module jk_excite_lut
  import jk_pkg::*;
(
  input  logic       q_cur,
  input  logic       tgt_bit,
  output logic [1:0] jk
);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves jk unassigned and no latch is inferred.
    jk = EXC_HOLD;
    if (q_cur != tgt_bit) begin
`ifdef JK_TOGGLE_PREF_EN
      jk = EXC_TOG;
`else
      jk = tgt_bit ? EXC_SET : EXC_RST;
`endif
    end
  end

endmodule

// File: rtl/jk_excite_driver.sv
// Drives an external JK flip-flop toward requested target bits, checks Q after
// CHECK_LAT cycles and reports match/mismatch. Option macro: JK_TOGGLE_PREF_EN.
module jk_excite_driver
  import jk_pkg::*;
#(
  parameter int CHECK_LAT = 1,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  input  logic             q_in,
  input  logic             err_clr,
  output logic             j,
  output logic             k,
  output logic             done_valid,
  output logic             match,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(CHECK_LAT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             tgt_r;
  logic [1:0]       exc;

  jk_excite_lut u_lut (
    .q_cur   (q_in),
    .tgt_bit (tgt_bit),
    .jk      (exc)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      tgt_r      <= 1'b0;
      j          <= 1'b0;
      k          <= 1'b0;
      tgt_ready  <= 1'b1;
      done_valid <= 1'b0;
      match      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tgt_valid) begin
            tgt_r     <= tgt_bit;
            {j, k}    <= exc;
            tgt_ready <= 1'b0;
            state     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          // The flip-flop has sampled J/K on this edge; release them so it holds.
          {j, k}   <= EXC_HOLD;
          wait_cnt <= WAIT_LOAD;
          state    <= ST_CHECK;
        end
        ST_CHECK: begin
          if (wait_cnt == '0) begin
            match      <= (q_in == tgt_r);
            done_valid <= 1'b1;
            state      <= ST_REPORT;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: begin
          done_valid <= 1'b0;
          tgt_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  // Clear wins over a same-edge increment; the count saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (state == ST_REPORT && !match && err_count != ERR_MAX) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: doc/jk_excite_driver.md
Name: jk_excite_driver

Overview:
- Drives an external JK flip-flop so that its output follows a requested sequence of target bits.
- For each target it generates J/K from the JK excitation table, pulses them for one clock, waits for Q to settle, then checks Q and reports match or mismatch.
- Sits on the stimulus side of jk_ff. It is the reusable controller that benches and higher-level sequential blocks use in place of hand-written J/K waveforms.

Parameters:
- CHECK_LAT, 1: cycles to wait after the drive cycle before sampling q_in; legal range 1..15.
- ERR_W, 8: width of the mismatch counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tgt_valid  input  1  target bit offered.
- tgt_bit  input  1  desired next Q value.
- tgt_ready  output  1  driver can accept a target.
- q_in  input  1  Q of the driven JK flip-flop, which is clocked by the same clk.
- err_clr  input  1  synchronous clear of err_count.
- j  output  1  J to the flip-flop (registered).
- k  output  1  K to the flip-flop (registered).
- done_valid  output  1  one-cycle result strobe.
- match  output  1  q_in equalled the target at check time; valid while done_valid=1.
- err_count  output  ERR_W  saturating mismatch count.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, j=0, k=0, tgt_ready=1, done_valid=0, match=0, err_count=0.
- Reset mid-operation aborts the transaction with no report. j and k return to 0 immediately, so the flip-flop holds.
- FSM states: IDLE, DRIVE, CHECK, REPORT. All outputs are registered.
- IDLE:
  - tgt_ready=1, j=k=0.
  - Accept occurs at a rising edge with tgt_valid=1. On accept, latch tgt_bit into tgt_r and q_in into q_cur, load j/k per the excitation rule, and go to DRIVE.
- Excitation rule (default):
  - 0->0: J=0, K=0.
  - 0->1: J=1, K=0.
  - 1->0: J=0, K=1.
  - 1->1: J=0, K=0.
  - Don't-cares are filled with 0, so the flip-flop is never toggled.
- DRIVE:
  - Exactly one cycle; j/k hold the excitation value. The flip-flop samples them on the edge that ends this cycle.
  - Next edge: j=k=0, load wait counter with CHECK_LAT-1, go to CHECK.
- CHECK:
  - Lasts CHECK_LAT cycles, with j=k=0.
  - On the edge where the counter is 0: match <= (q_in==tgt_r), done_valid <= 1, go to REPORT.
- REPORT:
  - done_valid=1 for exactly one cycle.
  - err_count increments on that edge if match=0, saturating at all-ones.
  - Next edge: done_valid=0, tgt_ready=1, go to IDLE.
- tgt_ready is 0 in DRIVE, CHECK and REPORT. tgt_valid is ignored there and must be held by the source.
- Latency: accept edge to done_valid high is 1+CHECK_LAT cycles. Throughput is one target per 3+CHECK_LAT cycles.
- err_clr:
  - Zeroes err_count on the next edge in any state.
  - err_clr has priority over a simultaneous increment.
- Boundary cases:
  - err_count at max with a mismatch stays at max.
  - tgt_bit equal to q_cur still runs the full sequence with J=K=0, acting as a hold check.

Optional Feature:
- Macro: JK_TOGGLE_PREF_EN.
- Defined: don't-cares are filled with 1 on changing transitions, so 0->1 and 1->0 both drive J=1, K=1. Holds still drive J=0, K=0. This exercises the toggle path of the flip-flop.
- Undefined: the default excitation rule applies. Timing, handshake and reporting are identical in both builds.

Decomposition:
- Shared package jk_pkg holds:
  - the state enum (IDLE, DRIVE, CHECK, REPORT);
  - localparam excitation constants (EXC_HOLD, EXC_SET, EXC_RST, EXC_TOG as 2-bit {J,K});
  - the CHECK_LAT upper bound.
- One sub-module is natural: jk_excite_lut, a combinational function of (q_cur, tgt_bit) to {j,k}. It contains the JK_TOGGLE_PREF_EN selection.
- The FSM, wait counter and error counter stay in the top module.

Test Plan (bench instantiates jk_excite_driver wired to jk_ff; CHECK_LAT=1, ERR_W=8):
- Reset: hold rst_n=0 for 3 cycles while driving tgt_valid=1 -> tgt_ready=1, j=k=0, done_valid=0, err_count=0 throughout, and no accept occurs.
- Set: Q=0, send tgt_bit=1 -> one cycle of J=1,K=0 (J=1,K=1 with the macro); done_valid 2 cycles after accept with match=1; q_in=1; err_count=0.
- Sequence: send targets 1,0,0,1,1 back-to-back -> five done_valid pulses 4 cycles apart, all match=1, final q_in=1. Handshake timing is the same in both builds.
- Fault: force q_in stuck at 0, send target 1 -> match=0, err_count=1. Then err_clr asserted on the same edge as a second mismatch increment -> err_count=0.
- Saturation: ERR_W=2 with q_in stuck, 5 mismatching targets -> err_count reaches 3 and stays 3.
- Abort: assert rst_n=0 during CHECK -> j=k=0 immediately, no done_valid; after release, tgt_ready=1 and the next target completes normally.
